// File: rtl/seg_letter_encoder.sv
// Segment-pattern to letter-code encoder feeding a small FWFT FIFO; bad patterns are dropped and counted.
// Optional: define DUP_SUPPRESS_EN to drop recognized codes equal to the previous recognized code.
module seg_letter_encoder #(
    parameter int          DEPTH      = 4,
    parameter logic [4:0]  BLANK_CODE = 5'd31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_seg,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_code,
    output logic                       err_pulse,
    output logic [7:0]                 err_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          hit;
    logic [4:0]    code;
    logic          accept, pop, push;

    always_comb begin
        hit  = 1'b1;
        code = 5'd0;
        case (in_seg)
            7'h77: code = 5'd0;
            7'h1F: code = 5'd1;
            7'h58: code = 5'd2;
            7'h3D: code = 5'd3;
            7'h4F: code = 5'd4;
            7'h47: code = 5'd5;
            7'h5E: code = 5'd6;
            7'h37: code = 5'd7;
            7'h3C: code = 5'd8;
            7'h0E: code = 5'd9;
            7'h15: code = 5'd10;
            7'h1D: code = 5'd11;
            7'h67: code = 5'd12;
            7'h05: code = 5'd13;
            7'h5B: code = 5'd14;
            7'h3B: code = 5'd15;
            7'h7F: code = BLANK_CODE;
            default: hit = 1'b0;
        endcase
    end

    assign in_ready   = (level != LW'(DEPTH));
    assign out_valid  = (level != '0);
    assign out_code   = mem[rd_ptr];
    assign fifo_level = level;
    assign accept     = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

`ifdef DUP_SUPPRESS_EN
    logic [4:0] last_code;
    logic       last_vld;

    assign push = accept && hit && !(last_vld && (code == last_code));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_code <= 5'd0;
            last_vld  <= 1'b0;
        end else if (accept && hit) begin
            last_code <= code;
            last_vld  <= 1'b1;
        end
    end
`else
    assign push = accept && hit;
`endif

    // mem is reset so out_code reads 0 before the first write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 5'd0;
        end else if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= accept && !hit;
            if (accept && !hit && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule
